mux_4_1_rr_sel: RTL and testbench
=================================

// Module: mux_4_1_rr_sel
//
// PURPOSE
// - Round-robin select generator that drives the s1/s0 select lines of the 4:1 mux.
// - Arbitrates four request lines and grants one channel at a time.
// - Holds each grant for a programmable number of accepted transfers, or until the request drops.
// - A downstream consumer paces transfers with ready; valid marks cycles where the mux output is meaningful.
//
// PARAMETERS
// - HOLD_CYCLES  default 4  accepted transfers per grant before forced rotation; legal range 1..255
// - CNT_W        default 8  dwell counter width; must satisfy HOLD_CYCLES <= 2**CNT_W-1
//
// PORTS
// - clk    input   1  rising-edge clock, single domain
// - rst_n  input   1  asynchronous active-low reset
// - req    input   4  per-channel request; req[i] asks for mux input i
// - ready  input   1  downstream accepts the mux output this cycle
// - s1     output  1  mux select MSB (registered)
// - s0     output  1  mux select LSB (registered)
// - gnt    output  4  one-hot grant; gnt[{s1,s0}] is high while valid
// - valid  output  1  a channel is granted and the mux output is live
// - lock   input   1  present only with MUX_ARB_LOCK_EN (see CONFIGURATION)
//
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - s1=0, s0=0, gnt=4'b0000, valid=0, state=IDLE, dwell counter=0.
//   - Round-robin pointer last=3, so channel 0 has top priority after reset.
// - States: IDLE and GRANT.
// - IDLE:
//   - valid=0 and gnt=0; s1/s0 hold their last value.
//   - If req!=0, select the first requesting channel searching last+1, last+2, ... (mod 4).
//   - Next edge: {s1,s0}=sel, gnt=onehot(sel), valid=1, counter=HOLD_CYCLES-1, state=GRANT.
//   - Latency: req asserted in cycle N -> valid high in cycle N+1.
// - GRANT:
//   - A transfer is counted on any cycle where valid&ready.
//   - On a transfer with counter!=0, decrement the counter.
//   - ready=0 stalls the counter and holds the grant indefinitely.
// - Release happens on the edge after either condition:
//   - (a) a transfer with counter==0; or
//   - (b) req[sel]==0 (requester withdrew; no transfer is counted that cycle even if ready=1).
// - On release:
//   - last=sel.
//   - Re-arbitrate among req, excluding sel on that same edge.
//   - If another channel requests, grant it on the same edge (no idle bubble; valid stays 1, counter reloads).
//   - Otherwise go to IDLE (valid=0, gnt=0).
// - A sole requester that releases via (a) with req still high:
//   - Drops valid for one IDLE cycle.
//   - Is then re-granted, because it is the only candidate.
// - Invariants:
//   - s1/s0 change only on the edge where gnt changes; select is glitch-free relative to valid.
//   - gnt is always one-hot or zero; gnt!=0 exactly when valid=1.
//   - Select encoding: {s1,s0}=2'b00 -> i0, 01 -> i1, 10 -> i2, 11 -> i3.
// - Reset asserted mid-grant: all outputs clear immediately (async); pointer returns to 3.
// - HOLD_CYCLES=1: every accepted transfer forces rotation.
//
// CONFIGURATION
// - MUX_ARB_LOCK_EN defined:
//   - Adds the lock input.
//   - While in GRANT with lock=1, condition (a) is ignored; the counter saturates at 0.
//   - Release then occurs only via (b) or via (a) on a later cycle with lock=0.
// - MUX_ARB_LOCK_EN undefined:
//   - The lock port is absent; release rules are exactly (a) and (b).
//
// TESTING
// - Reset then req=4'b0001, ready=1:
//   - Cycle 1: valid=1, {s1,s0}=00, gnt=0001.
//   - After 4 transfers: one IDLE cycle, then re-grant of ch0.
// - req=4'b1111, ready=1, HOLD_CYCLES=4:
//   - Grants rotate 0,1,2,3,0 every 4 cycles.
//   - valid stays high throughout; s1/s0 step 00->01->10->11.
// - Grant ch2 with req=4'b0100, ready=0 for 10 cycles:
//   - Grant held; counter frozen at 3.
//   - ready=1 -> release after exactly 4 further cycles.
// - Grant ch1 with req=4'b1010; drop req[1] after 1 transfer:
//   - Next edge: gnt=1000, {s1,s0}=11, counter=3.
// - Assert rst_n=0 mid-grant of ch3:
//   - Outputs zero the same cycle, no clock edge needed.
//   - Release with req=4'b1001 -> ch0 granted first.
// - MUX_ARB_LOCK_EN build, lock=1, req=4'b0011, grant ch0:
//   - ch0 held past 4 transfers.
//   - lock=0 -> rotates to ch1 on the next transfer.

Source files
------------

// File: rtl/mux_4_1_rr_sel.sv
// Round-robin select generator for a 4:1 mux: arbitrates req[3:0], drives registered s1/s0 and one-hot gnt.
// Latency: req in cycle N -> valid/gnt/select in cycle N+1; back-to-back handover on release, no bubble.
// Backpressure: ready=0 freezes the dwell counter and holds the grant; optional lock (MUX_ARB_LOCK_EN) extends it.
module mux_4_1_rr_sel #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       ready,
`ifdef MUX_ARB_LOCK_EN
    input  logic       lock,
`endif
    output logic       s1,
    output logic       s0,
    output logic [3:0] gnt,
    output logic       valid
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         sel_q, sel_nxt;
    logic [1:0]         last_q, last_nxt;
    logic [3:0]         gnt_q, gnt_nxt;
    logic               valid_q, valid_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;

    logic               req_cur;
    logic               xfer;
    logic               withdraw;
    logic               cnt_zero;
    logic               hold_a;
    logic               release_now;
    logic [2:0]         pick_idle;
    logic [2:0]         pick_rel;

    localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

    // First requester searching ptr+1, ptr+2, ptr+3, ptr (mod 4); returns {found, index}.
    function automatic logic [2:0] rr_pick(input logic [3:0] cand, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // Walk from lowest to highest priority so the highest-priority hit is written last.
        for (int k = 4; k >= 1; k--) begin
            idx = ptr + 2'(k);
            if (cand[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    // Grant-phase qualifiers: a withdrawn request is never counted as a transfer.
    always_comb begin
        req_cur  = req[sel_q];
        withdraw = (state == GRANT) && !req_cur;
        xfer     = (state == GRANT) && valid_q && ready && req_cur;
        cnt_zero = (cnt_q == '0);
`ifdef MUX_ARB_LOCK_EN
        hold_a   = lock;
`else
        hold_a   = 1'b0;
`endif
        release_now = withdraw || (xfer && cnt_zero && !hold_a);
        pick_idle   = rr_pick(req, last_q);
        pick_rel    = rr_pick(req & ~(4'b0001 << sel_q), sel_q);
    end

    // Next-state and next-output logic; all registers hold by default.
    always_comb begin
        state_nxt = state;
        sel_nxt   = sel_q;
        last_nxt  = last_q;
        gnt_nxt   = gnt_q;
        valid_nxt = valid_q;
        cnt_nxt   = cnt_q;

        unique case (state)
            IDLE: begin
                valid_nxt = 1'b0;
                gnt_nxt   = 4'b0000;
                if (pick_idle[2]) begin
                    state_nxt = GRANT;
                    sel_nxt   = pick_idle[1:0];
                    gnt_nxt   = 4'b0001 << pick_idle[1:0];
                    valid_nxt = 1'b1;
                    cnt_nxt   = CNT_RELOAD;
                end
            end
            GRANT: begin
                if (release_now) begin
                    last_nxt = sel_q;
                    if (pick_rel[2]) begin
                        // Direct handover: select and grant move together, valid stays high.
                        sel_nxt   = pick_rel[1:0];
                        gnt_nxt   = 4'b0001 << pick_rel[1:0];
                        valid_nxt = 1'b1;
                        cnt_nxt   = CNT_RELOAD;
                    end else begin
                        // Select lines keep their last value while idle.
                        state_nxt = IDLE;
                        gnt_nxt   = 4'b0000;
                        valid_nxt = 1'b0;
                        cnt_nxt   = '0;
                    end
                end else if (xfer && !cnt_zero) begin
                    cnt_nxt = cnt_q - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; pointer resets to 3 so channel 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            sel_q   <= 2'b00;
            last_q  <= 2'b11;
            gnt_q   <= 4'b0000;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            sel_q   <= sel_nxt;
            last_q  <= last_nxt;
            gnt_q   <= gnt_nxt;
            valid_q <= valid_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    assign s1    = sel_q[1];
    assign s0    = sel_q[0];
    assign gnt   = gnt_q;
    assign valid = valid_q;

`ifndef SYNTHESIS
    // Grant is one-hot or zero, non-zero exactly while valid, and always matches the select lines.
    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt_q));
    a_gnt_valid   : assert property (@(posedge clk) disable iff (!rst_n) (gnt_q != 4'b0000) == valid_q);
    a_gnt_sel     : assert property (@(posedge clk) disable iff (!rst_n) valid_q |-> gnt_q[sel_q]);
`endif

endmodule

// File: tb/tb_mux_4_1_rr_sel.sv
module tb_mux_4_1_rr_sel;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       ready;
`ifdef MUX_ARB_LOCK_EN
    logic       lock;
`endif
    logic       s1, s0, valid;
    logic [3:0] gnt;
    logic       h1_s1, h1_s0, h1_valid;
    logic [3:0] h1_gnt;

    int n_cmp;
    int n_err;

    mux_4_1_rr_sel #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .ready (ready),
`ifdef MUX_ARB_LOCK_EN
        .lock  (lock),
`endif
        .s1    (s1),
        .s0    (s0),
        .gnt   (gnt),
        .valid (valid)
    );

    // Second instance exercising the HOLD_CYCLES=1 boundary on the same stimulus.
    mux_4_1_rr_sel #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut_h1 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .ready (ready),
`ifdef MUX_ARB_LOCK_EN
        .lock  (lock),
`endif
        .s1    (h1_s1),
        .s0    (h1_s0),
        .gnt   (h1_gnt),
        .valid (h1_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
        lock  = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        req   = 4'b0000;
        ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
        lock  = 1'b0;
`endif
        #12;
        chk("rst_sel",   {30'd0, s1, s0}, 32'd0);
        chk("rst_gnt",   {28'd0, gnt}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);

        // Sole requester ch0: 4 transfers, one idle cycle, re-grant.
        do_reset();
        req   = 4'b0001;
        ready = 1'b1;
        tick();
        chk("s1_grant_valid", {31'd0, valid}, 32'd1);
        chk("s1_grant_sel",   {30'd0, s1, s0}, 32'd0);
        chk("s1_grant_gnt",   {28'd0, gnt}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("s1_hold_valid", {31'd0, valid}, 32'd1);
        end
        tick();
        chk("s1_idle_valid", {31'd0, valid}, 32'd0);
        chk("s1_idle_gnt",   {28'd0, gnt}, 32'h0);
        tick();
        chk("s1_regrant_valid", {31'd0, valid}, 32'd1);
        chk("s1_regrant_gnt",   {28'd0, gnt}, 32'h1);

        // All requesting: rotate every 4 transfers (HOLD=1 instance every transfer).
        do_reset();
        req   = 4'b1111;
        ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            logic [1:0] e4;
            logic [1:0] e1;
            tick();
            e4 = 2'((k / 4) % 4);
            e1 = 2'(k % 4);
            chk("rot_valid", {31'd0, valid}, 32'd1);
            chk("rot_sel",   {30'd0, s1, s0}, {30'd0, e4});
            chk("rot_gnt",   {28'd0, gnt}, {28'd0, 4'b0001 << e4});
            chk("h1_rot_gnt", {28'd0, h1_gnt}, {28'd0, 4'b0001 << e1});
        end

        // ch2 stalled by ready=0, then exactly 4 transfers to release.
        do_reset();
        req   = 4'b0100;
        ready = 1'b0;
        tick();
        for (int k = 0; k < 10; k++) begin
            chk("stall_gnt", {28'd0, gnt}, 32'h4);
            chk("stall_sel", {30'd0, s1, s0}, 32'd2);
            tick();
        end
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_drain_valid", {31'd0, valid}, 32'd1);
        end
        tick();
        chk("stall_release_valid", {31'd0, valid}, 32'd0);
        req = 4'b0000;

        // ch1 granted, withdraws after one transfer; ch3 takes over with fresh count.
        do_reset();
        req   = 4'b1010;
        ready = 1'b1;
        tick();
        chk("wd_first_gnt", {28'd0, gnt}, 32'h2);
        chk("wd_first_sel", {30'd0, s1, s0}, 32'd1);
        tick();
        chk("wd_after1_gnt", {28'd0, gnt}, 32'h2);
        req = 4'b1000;
        tick();
        chk("wd_handover_gnt",   {28'd0, gnt}, 32'h8);
        chk("wd_handover_sel",   {30'd0, s1, s0}, 32'd3);
        chk("wd_handover_valid", {31'd0, valid}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("wd_ch3_hold_gnt", {28'd0, gnt}, 32'h8);
        end
        tick();
        chk("wd_ch3_release_valid", {31'd0, valid}, 32'd0);

        // Asynchronous reset mid-grant of ch3, then ch0 wins after release.
        do_reset();
        req   = 4'b1000;
        ready = 1'b0;
        tick();
        chk("ar_pre_gnt", {28'd0, gnt}, 32'h8);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_gnt",   {28'd0, gnt}, 32'h0);
        chk("ar_valid", {31'd0, valid}, 32'd0);
        chk("ar_sel",   {30'd0, s1, s0}, 32'd0);
        req = 4'b1001;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("ar_after_gnt", {28'd0, gnt}, 32'h1);
        chk("ar_after_sel", {30'd0, s1, s0}, 32'd0);
        chk("ar_h1_after_gnt", {28'd0, h1_gnt}, 32'h1);

`ifdef MUX_ARB_LOCK_EN
        // Lock holds ch0 past its dwell; unlocking rotates on the next transfer.
        do_reset();
        req   = 4'b0011;
        ready = 1'b1;
        lock  = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            chk("lock_hold_gnt", {28'd0, gnt}, 32'h1);
        end
        lock = 1'b0;
        tick();
        chk("lock_rotate_gnt", {28'd0, gnt}, 32'h2);
        chk("lock_rotate_sel", {30'd0, s1, s0}, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
